// File: rtl/mac_dot_sequencer_if.sv
// Operand/result bus between the convolution lane, the dot-product sequencer and its MAC.
// The sequencer is the slave. The lane-side driver and the MAC model are the master.
interface mac_dot_sequencer_if #(
  parameter int N  = 8,
  parameter int CW = 4
);
  logic          start;
  logic [CW-1:0] len;
  logic [N-1:0]  bias;
  logic          busy;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_act;
  logic [N-1:0]  in_wgt;
  logic          mac_ce;
  logic          mac_clr;
  logic [N-1:0]  mac_a;
  logic [N-1:0]  mac_b;
  logic [N-1:0]  mac_c;
  logic [N-1:0]  mac_p;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_data;

  modport slave (
    input  start, len, bias, in_valid, in_act, in_wgt, mac_p, out_ready,
    output busy, in_ready, mac_ce, mac_clr, mac_a, mac_b, mac_c, out_valid, out_data
  );

  modport master (
    output start, len, bias, in_valid, in_act, in_wgt, mac_p, out_ready,
    input  busy, in_ready, mac_ce, mac_clr, mac_a, mac_b, mac_c, out_valid, out_data
  );
endinterface

// File: rtl/mac_dot_sequencer.sv
// Feeds activation/weight pairs to an external registered MAC and returns bias + sum(a*b).
// The MAC output is fed back as the addend after the first term.
module mac_dot_sequencer #(
  parameter int N       = 8,
  parameter int LEN_MAX = 9,
  parameter int CW      = 4
) (
  input logic                 clk_i,
  input logic                 sclr_i,
  mac_dot_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

  if ((2 ** CW) <= LEN_MAX) begin : gBadCw
    $error("CW too narrow to count LEN_MAX elements");
  end

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] len_q, len_d;
  logic [N-1:0]  bias_q, bias_d;
  logic [N-1:0]  result_q, result_d;
  logic          seenFirst_q, seenFirst_d;
  logic          accept;

  always_ff @(posedge clk_i) begin
    if (sclr_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      bias_q      <= '0;
      result_q    <= '0;
      seenFirst_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      bias_q      <= bias_d;
      result_q    <= result_d;
      seenFirst_q <= seenFirst_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    bias_d       = bias_q;
    result_d     = result_q;
    seenFirst_d  = seenFirst_q;
    accept       = 1'b0;
    bus.busy      = 1'b1;
    bus.in_ready  = 1'b0;
    bus.mac_ce    = 1'b0;
    bus.mac_a     = '0;
    bus.mac_b     = '0;
    bus.mac_c     = '0;
    bus.out_valid = 1'b0;

    unique case (state_q)
      IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) begin
          len_d       = bus.len;
          bias_d      = bus.bias;
          cnt_d       = '0;
          seenFirst_d = 1'b0;
          if (bus.len == '0) begin
            result_d = bus.bias;
            state_d  = DONE;
          end else begin
            state_d  = ACCUM;
          end
        end
      end
      ACCUM: begin
        // One MAC term per accepted pair; the MAC latency lines up with the mac_p feedback.
        bus.in_ready = 1'b1;
        accept       = bus.in_valid;
        bus.mac_ce   = accept;
        bus.mac_a    = bus.in_act;
        bus.mac_b    = bus.in_wgt;
        bus.mac_c    = seenFirst_q ? bus.mac_p : bias_q;
        if (accept) begin
          cnt_d       = cnt_q + CW'(1);
          seenFirst_d = 1'b1;
          if (cnt_q == len_q - CW'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        result_d = bus.mac_p;
        state_d  = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.out_data = result_q;
  assign bus.mac_clr  = sclr_i;

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Randomised and directed bench for mac_dot_sequencer with a behavioural MAC and a result scoreboard.
// Expected dot products come from plain arithmetic over the issued pairs.
module tb_mac_dot_sequencer;

  localparam int N  = 8;
  localparam int CW = 4;

  logic clk;
  logic sclr;

  mac_dot_sequencer_if #(.N(N), .CW(CW)) bus ();

  mac_dot_sequencer #(.N(N), .LEN_MAX(9), .CW(CW)) dut (
    .clk_i  (clk),
    .sclr_i (sclr),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered MAC the sequencer drives: p <= a*b + c, truncated to N bits.
  always_ff @(posedge clk) begin
    if (bus.mac_clr) bus.mac_p <= '0;
    else if (bus.mac_ce) bus.mac_p <= N'(bus.mac_a * bus.mac_b + bus.mac_c);
  end

  int          vecCount = 0;
  int          misCount = 0;
  int          ceCount  = 0;
  logic [7:0]  expQ[$];
  int          actQ[$];
  int          wgtQ[$];
  bit          validPat[$];

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    vecCount++;
    if (got !== want) begin
      misCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard on every result handshake, and counts MAC enables.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.mac_ce === 1'b1) ceCount++;
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        if (expQ.size() == 0) begin
          vecCount++;
          misCount++;
          $display("[TB] FAIL spurious result: got 0x%0h, expected no result at %0t", bus.out_data, $time);
        end else begin
          checkOutput("result", bus.out_data, expQ.pop_front());
        end
      end
    end
  end

  task automatic applyStimulus(input int len, input logic [7:0] bias, input int gapPct,
                               input int holdCycles, input bit pulseStart);
    logic [31:0] sum;
    logic [7:0]  expVal;
    int          sent;
    int          guard;
    int          waitCycles;
    int          ceStart;
    bit          acc;
    sum = 32'(bias);
    for (int i = 0; i < len; i++) sum += 32'(actQ[i] * wgtQ[i]);
    expVal = sum[7:0];
    expQ.push_back(expVal);
    ceStart = ceCount;

    bus.start = 1'b1;
    bus.len   = CW'(len);
    bus.bias  = bias;
    stepCycle();
    bus.start = 1'b0;
    bus.len   = CW'($urandom_range(15));
    bus.bias  = 8'($urandom_range(255));
    checkOutput("busy after start", 32'(bus.busy), 1);
    checkOutput("in_ready after start", 32'(bus.in_ready), 32'(len != 0));

    sent  = 0;
    guard = 0;
    while (sent < len && guard < 500) begin
      if (validPat.size() > 0) bus.in_valid = validPat.pop_front();
      else bus.in_valid = ($urandom_range(99) >= gapPct);
      bus.in_act = 8'(actQ[sent]);
      bus.in_wgt = 8'(wgtQ[sent]);
      acc = bus.in_valid && bus.in_ready;
      stepCycle();
      if (acc) sent++;
      guard++;
    end
    bus.in_valid = 1'b0;
    checkOutput("pairs accepted", 32'(sent), 32'(len));
    void'(actQ.pop_front());
    actQ.delete();
    wgtQ.delete();

    waitCycles = 0;
    while (bus.out_valid !== 1'b1 && waitCycles < 20) begin
      stepCycle();
      waitCycles++;
    end
    checkOutput("out_valid latency", 32'(waitCycles), (len == 0) ? 0 : 1);

    for (int h = 0; h < holdCycles; h++) begin
      bus.start = pulseStart;
      stepCycle();
      checkOutput("held out_valid", 32'(bus.out_valid), 1);
      checkOutput("held out_data", 32'(bus.out_data), 32'(expVal));
    end
    bus.out_ready = 1'b1;
    bus.start     = pulseStart;
    stepCycle();
    bus.out_ready = 1'b0;
    bus.start     = 1'b0;
    checkOutput("idle after handshake", 32'(bus.busy), 0);
    checkOutput("out_valid drops", 32'(bus.out_valid), 0);
    checkOutput("mac_ce cycles", 32'(ceCount - ceStart), 32'(len));
  endtask

  task automatic loadPairs(input int a0, input int w0, input int a1, input int w1,
                           input int a2, input int w2, input int cnt);
    actQ.delete();
    wgtQ.delete();
    if (cnt > 0) begin actQ.push_back(a0); wgtQ.push_back(w0); end
    if (cnt > 1) begin actQ.push_back(a1); wgtQ.push_back(w1); end
    if (cnt > 2) begin actQ.push_back(a2); wgtQ.push_back(w2); end
    actQ.push_back(0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int len;
    sclr          = 1'b1;
    bus.start     = 1'b0;
    bus.len       = '0;
    bus.bias      = '0;
    bus.in_valid  = 1'b0;
    bus.in_act    = '0;
    bus.in_wgt    = '0;
    bus.out_ready = 1'b0;
    stepCycle();
    stepCycle();
    checkOutput("reset busy", 32'(bus.busy), 0);
    checkOutput("reset in_ready", 32'(bus.in_ready), 0);
    checkOutput("reset mac_ce", 32'(bus.mac_ce), 0);
    checkOutput("reset out_valid", 32'(bus.out_valid), 0);
    checkOutput("reset out_data", 32'(bus.out_data), 0);
    checkOutput("mac_clr follows sclr", 32'(bus.mac_clr), 1);
    sclr = 1'b0;
    stepCycle();
    checkOutput("mac_clr released", 32'(bus.mac_clr), 0);

    $display("[TB] directed: back-to-back len=3");
    loadPairs(1, 4, 2, 5, 3, 6, 3);
    applyStimulus(3, 8'd2, 0, 0, 1'b0);

    $display("[TB] directed: gapped valid pattern");
    loadPairs(1, 4, 2, 5, 3, 6, 3);
    validPat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    applyStimulus(3, 8'd2, 0, 0, 1'b0);

    $display("[TB] directed: modulo wrap");
    loadPairs(16, 16, 16, 1, 0, 0, 2);
    applyStimulus(2, 8'd0, 0, 0, 1'b0);

    $display("[TB] directed: len=0");
    loadPairs(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 8'h5A, 0, 0, 1'b0);

    $display("[TB] directed: backpressure in DONE with start pulses");
    loadPairs(7, 9, 11, 13, 0, 0, 2);
    applyStimulus(2, 8'h33, 0, 5, 1'b1);

    $display("[TB] directed: reset mid-accumulate");
    bus.start = 1'b1;
    bus.len   = CW'(3);
    bus.bias  = 8'd2;
    stepCycle();
    bus.start = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_act = 8'd1; bus.in_wgt = 8'd4;
    stepCycle();
    bus.in_act = 8'd2; bus.in_wgt = 8'd5;
    stepCycle();
    sclr = 1'b1;
    stepCycle();
    bus.in_valid = 1'b0;
    checkOutput("abort busy", 32'(bus.busy), 0);
    checkOutput("abort in_ready", 32'(bus.in_ready), 0);
    checkOutput("abort mac_ce", 32'(bus.mac_ce), 0);
    checkOutput("abort out_valid", 32'(bus.out_valid), 0);
    checkOutput("abort out_data", 32'(bus.out_data), 0);
    sclr = 1'b0;
    stepCycle();
    loadPairs(3, 3, 0, 0, 0, 0, 1);
    applyStimulus(1, 8'd1, 0, 0, 1'b0);

    $display("[TB] random transactions");
    for (int t = 0; t < 25; t++) begin
      len = $urandom_range(9);
      actQ.delete();
      wgtQ.delete();
      for (int i = 0; i < len; i++) begin
        actQ.push_back($urandom_range(255));
        wgtQ.push_back($urandom_range(255));
      end
      actQ.push_back(0);
      applyStimulus(len, 8'($urandom_range(255)), $urandom_range(60),
                    $urandom_range(3), 1'($urandom_range(1)));
    end

    repeat (4) stepCycle();
    checkOutput("scoreboard drained", 32'(expQ.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, misCount);
    $finish;
  end

endmodule

// File: doc/mac_dot_sequencer.md
# mac_dot_sequencer

Operand sequencer that drives the registered 8-bit multiply-accumulate unit (`p <= a*b + c` when `ce`) to compute one dot product of a runtime length with a bias. It accepts activation/weight pairs over a valid/ready stream and feeds them to the MAC. After the first term it routes the MAC output back as the addend. It returns the final sum on a valid/ready result port. It sits between the line-buffer/weight fetch logic and the MAC in each convolution lane.

## Interface
- `N`, default 8: data width of operands, bias, MAC ports and result.
- `LEN_MAX`, default 9: maximum dot-product length (3x3 kernel).
- `CW`, default 4: width of `len` and the element counter; `2^CW > LEN_MAX`.

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `sclr`  in  1  reset, synchronous, active-high.
- `start`  in  1  one-cycle request to begin a dot product; honoured only in IDLE.
- `len`  in  CW  number of pairs, sampled on accepted `start`; legal 0..LEN_MAX.
- `bias`  in  N  initial addend, sampled on accepted `start`.
- `busy`  out  1  high in every state except IDLE.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  sequencer accepts a pair this cycle.
- `in_act`  in  N  activation operand.
- `in_wgt`  in  N  weight operand.
- `mac_ce`  out  1  MAC clock enable.
- `mac_clr`  out  1  MAC clear; equals `sclr`, combinational.
- `mac_a`  out  N  MAC operand a.
- `mac_b`  out  N  MAC operand b.
- `mac_c`  out  N  MAC addend.
- `mac_p`  in  N  MAC registered result.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_data`  out  N  dot-product result.

## Operation
- States: IDLE, ACCUM, DRAIN, DONE.
- IDLE: `start` latches `len_q` and `bias_q`, clears `cnt`, and clears the `first` flag.
  - If `len == 0`, go to DONE with `result_q <= bias`.
  - Otherwise go to ACCUM.
- ACCUM: `in_ready = 1`. A pair is accepted when `in_valid & in_ready`.
  - `mac_ce` equals the accept signal. `mac_a = in_act` and `mac_b = in_wgt`, combinational passthrough.
  - `mac_c = bias_q` for the first accepted pair, else `mac_p`.
  - Each accept increments `cnt`. An accept with `cnt == len_q-1` moves the block to DRAIN.
- DRAIN: one cycle. `mac_p` now holds the final sum; `result_q <= mac_p`. Go to DONE.
- DONE: `out_valid = 1` and `out_data = result_q`, both stable until `out_ready`. On `out_ready`, go to IDLE.
- `start` outside IDLE is ignored, including `start` in DONE coincident with `out_ready`.
- Arithmetic: unsigned, modulo 2^N; the MAC truncates `a*b+c` to N bits. The sequencer adds no saturation.
- `mac_ce = 0` in IDLE, DRAIN and DONE, so `mac_p` holds.
- `len > LEN_MAX`: the result is undefined, but the FSM must still terminate after `len` accepts.

## Timing
- Reset, with `sclr` high at a rising edge:
  - state IDLE;
  - `cnt`, `len_q`, `bias_q` and `result_q` = 0;
  - `busy`, `in_ready`, `mac_ce` and `out_valid` = 0.
  - Reset mid-ACCUM, DRAIN or DONE aborts the operation; a pending result is discarded.
- Start to first possible accept: 1 cycle (`start` at edge k, `in_ready` high in cycle k+1).
- Back-to-back accepts: 1 pair per cycle with no bubbles. The MAC's one-cycle latency matches the feedback path.
- Last accept at edge E: `mac_p` is final after E; `result_q` is loaded at E+1; `out_valid` rises after E+1.
- `len = 0`: `out_valid` is high the cycle after the accepted `start`.
- Minimum turnaround: one IDLE cycle between the result handshake and the next accepted `start`.
- Backpressure: `in_valid` low in ACCUM stalls with no state change. `out_ready` low holds DONE indefinitely.

## Test plan
- N=8, len=3, bias=2, pairs (1,4), (2,5), (3,6) back-to-back, `out_ready=1` -> `out_data=34`. `out_valid` rises 2 cycles after the last accept and stays high 1 cycle.
- Same stimulus with `in_valid` toggling 1,0,0,1,0,1 -> `out_data=34`. `mac_ce` is high exactly 3 cycles.
- Wrap: len=2, bias=0, pairs (16,16), (16,1) -> `out_data=16` (272 mod 256).
- len=0, bias=0x5A -> `out_data=0x5A` one cycle after `start`. `in_ready` never rises.
- `out_ready` held low 5 cycles in DONE with `start` pulsed -> `out_data` is stable, `start` is ignored, and after the handshake the block is in IDLE.
- `sclr` asserted after 2 of 3 accepts -> next cycle all outputs are 0 and state is IDLE. A fresh len=1, bias=1, pair (3,3) gives 10.
